// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage datapath inter-stage registers.
// Holds the packed control word layout, its NOP value and the data payload
// widths used by each pipeline boundary.
package pipe_pkg;

  // Packed control word; the upper bits are padding to a 16-bit payload.
  typedef struct packed {
    logic [4:0] pad;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       jump;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       reg_dst;
  } ctrl_t;

  localparam int unsigned CTRL_BITS = $bits(ctrl_t);
  localparam ctrl_t       CTRL_NOP  = '0;

  // Data payload widths per pipeline boundary.
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_DATA_W  = 128;
  localparam int unsigned EX_MEM_DATA_W = 128;
  localparam int unsigned MEM_WB_DATA_W = 96;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single storage slot of a pipeline stage: valid bit, data payload and
// control payload, updated on the falling edge of clk.
// Ports:
//   clk, rst      stage clock (falling-edge active), async active-low reset
//   flush         drop the held beat; control goes to NOP, data retained
//   load          capture ld_data/ld_ctrl and mark valid
//   clear         drop the held beat (bubble); control goes to NOP
//   valid/data/ctrl  slot contents
// Priority: flush > load > clear.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = 128,
  parameter int unsigned       CTRL_W  = 16,
  parameter logic [CTRL_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      // Data is deliberately kept; only the control side becomes a bubble.
      valid_d = 1'b0;
      ctrl_d  = NOP_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      ctrl_d  = ld_ctrl;
    end else if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = NOP_VAL;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= NOP_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake and a
// 2-entry skid buffer (main + skid). in_ready is registered (!skid_valid), so
// there is no combinational path from out_ready to in_ready.
// All state changes on the falling edge of clk; rst is async active-low.
// Ports:
//   flush               discard held and incoming beats (wins over accept/pop)
//   in_valid/in_ready   upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready downstream handshake, out_data/out_ctrl payload
//   out_ctrl            forced to CTRL_NOP whenever out_valid is low
//   bubble_cnt          saturating bubble counter, only with PIPE_BUBBLE_CNT_EN
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = pipe_pkg::ID_EX_DATA_W,
  parameter int unsigned       CTRL_W   = pipe_pkg::CTRL_BITS,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  parameter int unsigned       CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
  logic              accept, pop;
  logic              main_load, main_clear, skid_load, skid_clear;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (pop && skid_valid) begin
      main_load  = 1'b1;
      skid_load  = accept;
      skid_clear = ~accept;
    end else if (pop) begin
      main_load  = accept;
      main_clear = ~accept;
    end else if (main_valid) begin
      skid_load  = accept;
    end else begin
      main_load  = accept;
    end
  end

  // Skid is only ever valid while main is valid, so when main loads with the
  // skid occupied it must be a drain; otherwise it takes the input beat.
  assign main_ld_data = skid_valid ? skid_data : in_data;
  assign main_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;

  pipe_skid_slot #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .NOP_VAL (CTRL_NOP)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .load    (main_load),
    .clear   (main_clear),
    .ld_data (main_ld_data),
    .ld_ctrl (main_ld_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  pipe_skid_slot #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .NOP_VAL (CTRL_NOP)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .load    (skid_load),
    .clear   (skid_clear),
    .ld_data (in_data),
    .ld_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  // Downstream logic that ignores valid still sees a bubble.
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;

`ifdef PIPE_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((!main_valid || flush) && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, async reset
// sequence, randomized handshake with scoreboard, and (with
// PIPE_BUBBLE_CNT_EN) bubble counter saturation.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_BUBBLE_CNT_EN
  logic [15:0]   bubble_cnt;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  logic [3:0]    b_bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .CTRL_NOP ('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl)
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

`ifdef PIPE_BUBBLE_CNT_EN
  pipe_stage_reg #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .CTRL_NOP ('0),
    .CNT_W    (4)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .flush      (1'b0),
    .in_valid   (1'b0),
    .in_ready   (b_in_ready),
    .in_data    ('0),
    .in_ctrl    ('0),
    .out_valid  (b_out_valid),
    .out_ready  (1'b1),
    .out_data   (b_out_data),
    .out_ctrl   (b_out_ctrl),
    .bubble_cnt (b_bubble_cnt)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic [15:0] ic;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [15:0] od;
    logic [15:0] oc;
    logic        ir;
  } vec_t;

  vec_t tbl[14];

  logic [15:0] q_data[$];
  logic [15:0] q_ctrl[$];

  initial begin
    logic        pend;
    logic [15:0] seq;
    int          delivered;
    int          sent;

    //            iv  in_data   in_ctrl   ordy fl   ov  out_data  out_ctrl  ir
    tbl[0]  = '{1'b1, 16'h1234, 16'h00A5, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h00A5, 1'b1};
    tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1};
    tbl[2]  = '{1'b1, 16'hAAAA, 16'h000A, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h000A, 1'b1};
    tbl[3]  = '{1'b1, 16'hBBBB, 16'h000B, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h000A, 1'b0};
    tbl[4]  = '{1'b1, 16'hCCCC, 16'h000C, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h000A, 1'b0};
    tbl[5]  = '{1'b1, 16'hCCCC, 16'h000C, 1'b1, 1'b0, 1'b1, 16'hBBBB, 16'h000B, 1'b1};
    tbl[6]  = '{1'b1, 16'hCCCC, 16'h000C, 1'b1, 1'b0, 1'b1, 16'hCCCC, 16'h000C, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hCCCC, 16'h0000, 1'b1};
    tbl[8]  = '{1'b1, 16'hDDDD, 16'h000D, 1'b0, 1'b0, 1'b1, 16'hDDDD, 16'h000D, 1'b1};
    tbl[9]  = '{1'b1, 16'hEEEE, 16'h000E, 1'b0, 1'b0, 1'b1, 16'hDDDD, 16'h000D, 1'b0};
    tbl[10] = '{1'b1, 16'hF0F0, 16'h000F, 1'b1, 1'b1, 1'b0, 16'hDDDD, 16'h0000, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hDDDD, 16'h0000, 1'b1};
    tbl[12] = '{1'b1, 16'h1357, 16'h0042, 1'b0, 1'b0, 1'b1, 16'h1357, 16'h0042, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1357, 16'h0000, 1'b1};

    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      in_ctrl   = tbl[i].ic;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      @(negedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tbl[i].od));
      check($sformatf("v%0d_out_ctrl", i),  32'(out_ctrl),  32'(tbl[i].oc));
      check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
    end
    flush = 1'b0;

    // Async reset between edges with main full.
    @(posedge clk);
    in_valid  = 1'b1;
    in_data   = 16'h5A5A;
    in_ctrl   = 16'h0077;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    check("ar_pre_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_ctrl",  32'(out_ctrl),  32'd0);
    check("ar_out_data",  32'(out_data),  32'd0);
    check("ar_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    rst = 1'b1;

    // Random handshake against a scoreboard queue.
    pend      = 1'b0;
    seq       = 16'h0100;
    delivered = 0;
    sent      = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      if (!pend) begin
        pend = ($urandom_range(0, 2) != 0);
        if (pend) begin
          in_data = seq;
          in_ctrl = seq ^ 16'h3C01;
        end
      end
      in_valid  = pend;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          check("rnd_underflow", 32'd1, 32'd0);
        end else begin
          check("rnd_data", 32'(out_data), 32'(q_data.pop_front()));
          check("rnd_ctrl", 32'(out_ctrl), 32'(q_ctrl.pop_front()));
          delivered++;
        end
      end
      if (!out_valid) check("rnd_nop_ctrl", 32'(out_ctrl), 32'd0);
      if (in_valid && in_ready) begin
        q_data.push_back(in_data);
        q_ctrl.push_back(in_ctrl);
        sent++;
        seq  = seq + 16'd1;
        pend = 1'b0;
      end
    end
    // Drain whatever is left; at most two beats are held.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        if (q_data.size() == 0) begin
          check("drain_underflow", 32'd1, 32'd0);
        end else begin
          check("drain_data", 32'(out_data), 32'(q_data.pop_front()));
          check("drain_ctrl", 32'(out_ctrl), 32'(q_ctrl.pop_front()));
          delivered++;
        end
      end
    end
    check("rnd_delivered", 32'(delivered), 32'(sent));
    check("rnd_queue_empty", 32'(q_data.size()), 32'd0);

`ifdef PIPE_BUBBLE_CNT_EN
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("bub_rst", 32'(b_bubble_cnt), 32'd0);
    @(posedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("bub_saturate", 32'(b_bubble_cnt), 32'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register for the 5-stage datapath. It replaces the hand-written per-stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a data payload, which is never cleared, and a control payload, which is forced to NOP on flush or bubble.
- Adds valid/ready handshaking and a 2-entry skid buffer, so a stage can stall without a combinational ready path from the downstream stage to the upstream stage.

Parameters:
- DATA_W, 128, width of data payload (operands, PC, instruction fields, immediate).
- CTRL_W, 16, width of control payload (RegDst, Branch, MemtoReg, ALUOp, etc., packed).
- CTRL_NOP, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid instruction.
- CNT_W, 16, width of bubble counter (optional feature only).

Ports:
- clk  in  1  stage clock; all state updates on falling edge of clk.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all held and incoming instructions.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  out_data/out_ctrl hold a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  registered data payload.
- out_ctrl  out  CTRL_W  registered control payload; CTRL_NOP when !out_valid.
- bubble_cnt  out  CNT_W  present only with PIPE_BUBBLE_CNT_EN.

Behaviour:
- Storage: main register (main_valid, data, ctrl) drives the outputs. Skid register (skid_valid, data, ctrl) sits behind it.
- Reset (rst=0, async): main_valid=0, skid_valid=0, all data=0, out_ctrl=CTRL_NOP, in_ready=1, bubble_cnt=0. Reset may assert mid-transfer; any in-flight beat is lost.
- Accept: a beat is taken at a falling edge when in_valid & in_ready. Pop: out_valid & out_ready.
- Latency: 1 half-cycle-aligned register stage. An accepted beat appears on the outputs after the same falling edge when main is empty or popping.
- Update rules at each falling edge, when flush=0:
  - pop & skid_valid: main <= skid. Skid takes the input beat if one is accepted, otherwise skid_valid <= 0.
  - pop & !skid_valid: main <= input beat if accepted, else main_valid <= 0.
  - !pop & main_valid & accept: skid <= input beat; skid_valid <= 1, so in_ready drops.
  - !main_valid & accept: main <= input beat.
  - otherwise hold. Data is never altered while held (stall).
- Ordering: beats leave in arrival order; the skid always drains to main before a newer beat.
- Full: main_valid & skid_valid gives in_ready=0. Upstream must hold in_valid/in_data steady.
- flush=1 at a falling edge:
  - main_valid <= 0, skid_valid <= 0, ctrl <= CTRL_NOP.
  - Data registers retain their values.
  - Any simultaneous accept is dropped; flush wins over accept and pop.
- Flush during reset has no effect.
- out_ctrl is combinationally CTRL_NOP whenever main_valid=0. Downstream logic that ignores valid therefore sees a bubble.

Optional Feature:
- Macro: PIPE_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt increments at each falling edge where out_valid was 0 before the edge, or where flush=1.
  - Saturates at all-ones.
  - Cleared only by rst.
- Undefined: port bubble_cnt and counter logic absent; no other behaviour change.

Decomposition:
- Shared package pipe_pkg holds:
  - Packed control typedef ctrl_t with fields RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, Ext_op, ALUOp[2:0], padded to CTRL_W.
  - localparam CTRL_NOP.
  - Per-stage DATA_W constants.
- One natural sub-module, pipe_skid_slot: a single valid+data+ctrl register with load/clear/flush. Instantiate it twice, as main and skid.

Test Plan:
- Reset, then in_valid=1, data=0x1234, ctrl=0x00A5, out_ready=1 -> after next falling edge: out_valid=1, out_data=0x1234, out_ctrl=0x00A5, in_ready=1.
- Stall: out_ready=0 with 3 consecutive beats A, B, C -> A held in main, B in skid, in_ready=0, C held upstream. Then out_ready=1 -> outputs A, B, C in order, no loss or duplication.
- Flush with main and skid full, plus in_valid=1 -> next edge: out_valid=0, out_ctrl=0x0000, in_ready=1, out_data unchanged, incoming beat not captured.
- Async reset asserted between clock edges with main full -> out_valid=0 and out_ctrl=CTRL_NOP immediately, without waiting for an edge.
- Random in_valid/out_ready (10k cycles), scoreboard comparison -> in-order delivery; out_ctrl=CTRL_NOP whenever out_valid=0.
- PIPE_BUBBLE_CNT_EN, CNT_W=4: 20 idle cycles -> bubble_cnt=15 (saturated). Also a build without the macro -> port absent and compiles.
